board_display_scanner: RTL and testbench
========================================

// Module: board_display_scanner
// PURPOSE
//  Read side of the 10x20 board store: scans the board via its display read port
//  (ra0 out, rd0 in) in raster order and renders 640x480 VGA.
//  Emits hsync/vsync/de/rgb; a frame-start pulse and a vblank flag let game logic
//  schedule board refreshes outside the visible board.
// PARAMETERS
//  H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48 : horizontal timing in pixels (total 800)
//  V_ACTIVE 480, V_FP 10, V_SYNC 2,  V_BP 33 : vertical timing in lines (total 525)
//  BOARD_X0 220, BOARD_Y0 40 : top-left pixel of the board window
//  CELL     20               : cell edge in pixels; board window is 10*CELL x 20*CELL
//  BG_RGB   12'h000          : colour outside the board window and during blanking
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  pix_ce     in   1   pixel-clock enable; all state advances only when high
//  ra0        out  8   board read address = row*10 + col, range 0..199
//  rd0        in   3   cell type at ra0 (0 = empty, 1..7 = piece type)
//  hsync      out  1   horizontal sync, active-low
//  vsync      out  1   vertical sync, active-low
//  de         out  1   data enable, high in the 640x480 active area
//  rgb        out  12  pixel colour {R[3:0],G[3:0],B[3:0]}
//  frame_start out 1   one-clk pulse when h=0,v=0 is entered (qualified by pix_ce)
//  vblank     out  1   high while v_cnt >= V_ACTIVE (undelayed counter domain)
// BEHAVIOUR
//  - Reset: h_cnt=v_cnt=0, ra0=0, hsync=vsync=1, de=0, rgb=BG_RGB,
//    frame_start=0, vblank=0, all pipeline stages cleared to blank. Reset mid-line
//    restarts the frame at (0,0) on the next pix_ce.
//  - Counters: h_cnt 0..799 wraps to 0 and increments v_cnt; v_cnt 0..524 wraps to 0.
//  - No divider: cell addressing uses incremental counters. sub_x counts 0..CELL-1
//    from h=BOARD_X0, col advances 0..9 on sub_x wrap. Likewise sub_y/row from
//    v=BOARD_Y0 (row 0..19). row_base (row*10) is kept by adding 10 on each row advance.
//  - in_board = h in [BOARD_X0, BOARD_X0+10*CELL) and v in [BOARD_Y0, BOARD_Y0+20*CELL).
//  - Pipeline (one stage per pix_ce, 3 stages):
//    S0 counters; S1 ra0 <= row_base+col registered (holds last value when !in_board);
//    S2 rd0 sampled, board RAM read latency must be <= 1 pix_ce period; S3 rgb/hsync/
//    vsync/de registered. Sync/de are delayed 3 stages so they align with rgb exactly.
//  - Colour LUT (S3): 0->12'h000, 1->12'h0FF, 2->12'h00F, 3->12'hF80, 4->12'hFF0,
//    5->12'h0F0, 6->12'hF0F, 7->12'hF00. !de -> 12'h000; de & !in_board -> BG_RGB.
//  - hsync low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync same rule on v.
//  - frame_start/vblank are undelayed (S0) so game logic may refresh before line 0 reaches S3.
//  - pix_ce low: every register including ra0 holds; outputs stable.
// CONFIGURATION
//  GRID_LINES_EN defined: pixels with sub_x==0 or sub_y==0 inside the board draw
//  12'h444 regardless of rd0 (cell gridlines); one extra compare, no latency change.
//  Undefined: cells render solid; gridline logic absent.
// TESTING
//  1 Reset, pix_ce=1 every clk, run 800*525 ticks -> hsync low 96 px/line starting at
//    de-aligned h=656, vsync low on lines 490-491, de high 640x480, one frame_start.
//  2 Board model returns rd0=ra0%8 -> pixel (220,40) rgb=12'h000 (addr 0); (240,40)=12'h0FF;
//    (239+180,40+380) i.e. addr 199 -> type 7 = 12'hF00.
//  3 Monitor ra0 over one frame -> only values 0..199; each row address held for 20 lines
//    and each value held 20 pixels; ra0 at board exit on line 439 = 199.
//  4 pix_ce=1 every 4th clk -> identical pixel sequence to test 1; outputs constant between enables.
//  5 Assert rst at h=300,v=200 for 1 clk -> next pix_ce outputs reset values; frame restarts at (0,0).
//  6 With GRID_LINES_EN, all-type-5 board -> (220,y in board)=12'h444, (221,41)=12'h0F0;
//    without it, (220,41)=12'h0F0.

Source files
------------

// File: rtl/board_display_scanner_if.sv
// Board read port and VGA video bundle for board_display_scanner.
// master = scanner side, slave = board store / display sink side.
interface board_display_scanner_if;

  logic [7:0]  ra0;
  logic [2:0]  rd0;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [11:0] rgb;
  logic        frame_start;
  logic        vblank;

  modport master (
    output ra0,
    input  rd0,
    output hsync,
    output vsync,
    output de,
    output rgb,
    output frame_start,
    output vblank
  );

  modport slave (
    input  ra0,
    output rd0,
    input  hsync,
    input  vsync,
    input  de,
    input  rgb,
    input  frame_start,
    input  vblank
  );

endinterface

// File: rtl/board_display_scanner.sv
// Raster scanner: reads the 10x20 board store and renders 640x480 VGA.
// Optional macro GRID_LINES_EN draws 12'h444 gridlines on cell edges.
module board_display_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BOARD_X0 = 220,
  parameter int BOARD_Y0 = 40,
  parameter int CELL     = 20,
  parameter logic [11:0] BG_RGB = 12'h000
) (
  input logic clk,
  input logic rst,
  input logic pix_ce,
  board_display_scanner_if.master bus
);

  localparam int SW = $clog2(CELL);

  localparam logic [9:0] H_LAST =
    10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST =
    10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [9:0] BX0 = 10'(BOARD_X0);
  localparam logic [9:0] BX1 = 10'(BOARD_X0 + 10 * CELL);
  localparam logic [9:0] BY0 = 10'(BOARD_Y0);
  localparam logic [9:0] BY1 = 10'(BOARD_Y0 + 20 * CELL);

  localparam logic [SW-1:0] SUB_MAX = SW'(CELL - 1);

`ifdef GRID_LINES_EN
  typedef struct packed {
    logic in_board;
    logic de;
    logic hs;
    logic vs;
    logic grid;
  } stage_t;

  localparam stage_t BLANK = '{
    in_board: 1'b0,
    de:       1'b0,
    hs:       1'b1,
    vs:       1'b1,
    grid:     1'b0
  };
`else
  typedef struct packed {
    logic in_board;
    logic de;
    logic hs;
    logic vs;
  } stage_t;

  localparam stage_t BLANK = '{
    in_board: 1'b0,
    de:       1'b0,
    hs:       1'b1,
    vs:       1'b1
  };
`endif

  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;
  logic          h_wrap;
  logic          v_wrap;
  logic          in_x;
  logic          in_y;

  logic [SW-1:0] sub_x;
  logic [SW-1:0] sub_y;
  logic [3:0]    col;
  logic [7:0]    row_base;

  stage_t        s0;
  stage_t        s1;
  stage_t        s2;
  logic [2:0]    cell2;
  logic [11:0]   pix_rgb;

  logic [7:0]    ra0_q;
  logic          hs_q;
  logic          vs_q;
  logic          de_q;
  logic [11:0]   rgb_q;
  logic          fs_q;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);
  assign h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
  assign v_nxt  = v_wrap ? 10'd0 : v_cnt + 10'd1;

  assign in_x = (h_cnt >= BX0) && (h_cnt < BX1);
  assign in_y = (v_cnt >= BY0) && (v_cnt < BY1);

  // S0 decode of the current counter position
  always_comb begin
    s0          = BLANK;
    s0.in_board = in_x && in_y;
    s0.de       = (h_cnt < HA) && (v_cnt < VA);
    s0.hs       = !((h_cnt >= HS0) && (h_cnt < HS1));
    s0.vs       = !((v_cnt >= VS0) && (v_cnt < VS1));
`ifdef GRID_LINES_EN
    s0.grid     = (sub_x == '0) || (sub_y == '0);
`endif
  end

  // Pixel and line counters
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (pix_ce) begin
      h_cnt <= h_nxt;
      if (h_wrap)
        v_cnt <= v_nxt;
    end
  end

  // Column tracking inside the board window, no divider
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_x <= '0;
      col   <= 4'd0;
    end else if (pix_ce) begin
      if (h_nxt == BX0) begin
        sub_x <= '0;
        col   <= 4'd0;
      end else if (in_x) begin
        if (sub_x == SUB_MAX) begin
          sub_x <= '0;
          col   <= col + 4'd1;
        end else begin
          sub_x <= sub_x + 1'b1;
        end
      end
    end
  end

  // Row tracking; row_base holds row*10 by accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_y    <= '0;
      row_base <= 8'd0;
    end else if (pix_ce && h_wrap) begin
      if (v_nxt == BY0) begin
        sub_y    <= '0;
        row_base <= 8'd0;
      end else if (in_y) begin
        if (sub_y == SUB_MAX) begin
          sub_y    <= '0;
          row_base <= row_base + 8'd10;
        end else begin
          sub_y <= sub_y + 1'b1;
        end
      end
    end
  end

  // S1: issue the board read address, hold it outside the board
  always_ff @(posedge clk) begin
    if (rst) begin
      ra0_q <= 8'd0;
      s1    <= BLANK;
    end else if (pix_ce) begin
      s1 <= s0;
      if (s0.in_board)
        ra0_q <= row_base + {4'd0, col};
    end
  end

  // S2: capture the cell type returned by the board store
  always_ff @(posedge clk) begin
    if (rst) begin
      s2    <= BLANK;
      cell2 <= 3'd0;
    end else if (pix_ce) begin
      s2    <= s1;
      cell2 <= bus.rd0;
    end
  end

  // Colour lookup for the S2 pixel
  always_comb begin
    pix_rgb = 12'h000;
    if (!s2.de) begin
      pix_rgb = 12'h000;
    end else if (!s2.in_board) begin
      pix_rgb = BG_RGB;
`ifdef GRID_LINES_EN
    end else if (s2.grid) begin
      pix_rgb = 12'h444;
`endif
    end else begin
      unique case (cell2)
        3'd0: pix_rgb = 12'h000;
        3'd1: pix_rgb = 12'h0FF;
        3'd2: pix_rgb = 12'h00F;
        3'd3: pix_rgb = 12'hF80;
        3'd4: pix_rgb = 12'hFF0;
        3'd5: pix_rgb = 12'h0F0;
        3'd6: pix_rgb = 12'hF0F;
        3'd7: pix_rgb = 12'hF00;
        default: pix_rgb = 12'h000;
      endcase
    end
  end

  // S3: register colour together with the delayed sync/de
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= BG_RGB;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
    end else if (pix_ce) begin
      rgb_q <= pix_rgb;
      hs_q  <= s2.hs;
      vs_q  <= s2.vs;
      de_q  <= s2.de;
    end
  end

  // Frame start pulse as the counters wrap into (0,0)
  always_ff @(posedge clk) begin
    if (rst)
      fs_q <= 1'b0;
    else
      fs_q <= pix_ce && h_wrap && v_wrap;
  end

  assign bus.ra0         = ra0_q;
  assign bus.rgb         = rgb_q;
  assign bus.hsync       = hs_q;
  assign bus.vsync       = vs_q;
  assign bus.de          = de_q;
  assign bus.frame_start = fs_q;
  assign bus.vblank      = (v_cnt >= VA);

endmodule

// File: tb/tb_board_display_scanner.sv
// Scoreboard bench for board_display_scanner on a shrunk video timing.
// Reference pixels come from plain arithmetic on the raster position.
module tb_board_display_scanner;

  localparam int HA = 32;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VA = 44;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int BX = 5;
  localparam int BY = 3;
  localparam int C  = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic [11:0] BG = 12'h000;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] rgb;
  } pix_t;

  logic clk = 1'b0;
  logic rst;
  logic pix_ce;

  board_display_scanner_if bus();

  board_display_scanner #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BOARD_X0(BX), .BOARD_Y0(BY), .CELL(C),
    .BG_RGB(BG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_ce(pix_ce),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [2:0] board [200];

  always_comb begin
    bus.rd0 = 3'd0;
    if (bus.ra0 < 8'd200)
      bus.rd0 = board[bus.ra0];
  end

  pix_t q[$];
  pix_t cur;
  int   mh;
  int   mv;
  int   exp_ra;
  bit   exp_fs;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [11:0] lut(input int t);
    case (t)
      0: return 12'h000;
      1: return 12'h0FF;
      2: return 12'h00F;
      3: return 12'hF80;
      4: return 12'hFF0;
      5: return 12'h0F0;
      6: return 12'hF0F;
      default: return 12'hF00;
    endcase
  endfunction

  function automatic bit in_board(input int h, input int v);
    return h >= BX && h < BX + 10 * C && v >= BY && v < BY + 20 * C;
  endfunction

  function automatic int addr(input int h, input int v);
    return ((v - BY) / C) * 10 + (h - BX) / C;
  endfunction

  function automatic pix_t blank_pix();
    pix_t p;
    p.hs = 1'b1;
    p.vs = 1'b1;
    p.de = 1'b0;
    p.rgb = 12'h000;
    return p;
  endfunction

  function automatic pix_t model_pix(input int h, input int v);
    pix_t p;
    bit   grid;
    p.de = h < HA && v < VA;
    p.hs = !(h >= HA + HF && h < HA + HF + HS);
    p.vs = !(v >= VA + VF && v < VA + VF + VS);
    grid = ((h - BX) % C == 0) || ((v - BY) % C == 0);
`ifndef GRID_LINES_EN
    grid = 1'b0;
`endif
    if (!p.de)
      p.rgb = 12'h000;
    else if (!in_board(h, v))
      p.rgb = BG;
    else if (grid)
      p.rgb = 12'h444;
    else
      p.rgb = lut(int'(board[addr(h, v)]));
    return p;
  endfunction

  task automatic check(input string n,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t pos=%0d,%0d)",
               n, act, exp, $time, mh, mv);
    end
  endtask

  task automatic fill_board(input int mode);
    for (int i = 0; i < 200; i++) begin
      if (mode == 0)
        board[i] = 3'(i % 8);
      else if (mode == 1)
        board[i] = 3'd5;
      else
        board[i] = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic model_reset();
    q.delete();
    q.push_back(blank_pix());
    q.push_back(blank_pix());
    mh = 0;
    mv = 0;
    exp_ra = 0;
    exp_fs = 1'b0;
  endtask

  task automatic step(input bit r, input bit c);
    @(negedge clk);
    rst = r;
    pix_ce = c;
    exp_fs = 1'b0;
    if (r) begin
      model_reset();
    end else if (c) begin
      q.push_back(model_pix(mh, mv));
      if (in_board(mh, mv))
        exp_ra = addr(mh, mv);
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT)
          mv = 0;
      end
      exp_fs = (mh == 0) && (mv == 0);
    end
  endtask

  task automatic reset_with(input int mode);
    step(1'b1, 1'b0);
    fill_board(mode);
    step(1'b1, 1'b0);
  endtask

  // Monitor: pop an expected pixel on each enabled edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cur = blank_pix();
        cur.rgb = BG;
      end else if (pix_ce) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL queue_empty: got no expected pixel (t=%0t)",
                   $time);
        end else begin
          cur = q.pop_front();
        end
      end
      check("hsync", 32'(bus.hsync), 32'(cur.hs));
      check("vsync", 32'(bus.vsync), 32'(cur.vs));
      check("de", 32'(bus.de), 32'(cur.de));
      check("rgb", 32'(bus.rgb), 32'(cur.rgb));
      check("ra0", 32'(bus.ra0), 32'(exp_ra));
      check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
      check("vblank", 32'(bus.vblank), 32'(mv >= VA));
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1;
    pix_ce = 1'b0;
    fill_board(0);
    model_reset();
    repeat (3) step(1'b1, 1'b0);

    repeat (2 * HT * VT + 10) step(1'b0, 1'b1);

    reset_with(1);
    for (int i = 0; i < HT * VT * 4 + 40; i++)
      step(1'b0, (i % 4) == 3);

    reset_with(2);
    for (int i = 0; i < 2 * HT * VT; i++) begin
      if (mh == 20 && mv == 20)
        break;
      step(1'b0, 1'b1);
    end
    step(1'b1, 1'b1);
    repeat (HT * VT + 5) step(1'b0, 1'b1);

    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 2999) == 0) begin
        reset_with(2);
      end else begin
        step(1'b0, $urandom_range(0, 2) != 0);
      end
    end

    repeat (4) step(1'b0, 1'b0);
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
